// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a multi-digit seven-segment display.
//
// Every scan slot has two phases. In GUARD all digits are off for GUARD_CYC cycles. In SHOW
// one digit is enabled for SCAN_DIV cycles and its effective code goes to the shared segment
// decoder. New data is loaded into a shadow register set. That set is copied into the active
// set only at a frame boundary, so a frame never shows a mix of old and new codes.
//
// Code encoding: 1xxxx = hex digit, 00000 = blank, 00001 = up arrow, 00010 = down arrow,
// 00011 = up and down.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   load_i         single-cycle strobe; captures load_data_i/blink_mask_i/lz_blank_i
//   load_data_i    5-bit code per digit; bits [5i+4:5i] belong to digit i (digit 0 rightmost)
//   blink_mask_i   1 = digit i blinks
//   lz_blank_i     1 = leading-zero blanking enabled
//   code_out_o     registered code for the segment decoder
//   dig_sel_o      registered one-hot, active-high digit enable (all zero in GUARD)
//   pending_o      shadow set holds data that has not been committed yet
//   frame_start_o  one-cycle pulse in the first GUARD cycle of digit 0 after a wrap
module display_scan_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD_CYC    = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [5*DIGITS-1:0]   load_data_i,
  input  logic [DIGITS-1:0]     blink_mask_i,
  input  logic                  lz_blank_i,
  output logic [4:0]            code_out_o,
  output logic [DIGITS-1:0]     dig_sel_o,
  output logic                  pending_o,
  output logic                  frame_start_o
);

  // One phase counter is shared by GUARD and SHOW, so it is sized for the longer of the two.
  localparam int unsigned CntMax = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV - 1 : GUARD_CYC - 1;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;
  localparam int unsigned FrmMax = BLINK_FRAMES - 1;
  localparam int unsigned FrmW   = (FrmMax > 0) ? $clog2(FrmMax + 1) : 1;
  localparam int unsigned IdxW   = $clog2(DIGITS);

  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DIGITS - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYC - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(SCAN_DIV - 1);
  localparam logic [FrmW-1:0] FrmLast   = FrmW'(BLINK_FRAMES - 1);

  localparam logic [4:0] CodeZero  = 5'b10000;
  localparam logic [4:0] CodeBlank = 5'b00000;

  // Elaboration-time parameter checks.
  if ((DIGITS < 2) || (DIGITS > 8)) begin : gen_digits_err
    $error("display_scan_ctrl: DIGITS must be in 2..8");
  end
  if (SCAN_DIV < 1) begin : gen_scan_err
    $error("display_scan_ctrl: SCAN_DIV must be >= 1");
  end
  if (GUARD_CYC < 1) begin : gen_guard_err
    $error("display_scan_ctrl: GUARD_CYC must be >= 1");
  end
  if (BLINK_FRAMES < 1) begin : gen_blink_err
    $error("display_scan_ctrl: BLINK_FRAMES must be >= 1");
  end

  typedef enum logic [0:0] {
    StGuard = 1'b0,
    StShow  = 1'b1
  } state_e;

  // Scan FSM state.
  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Registered outputs.
  logic [4:0]        code_out_q, code_out_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic              frame_start_q, frame_start_d;
  logic              pending_q, pending_d;

  // Shadow and active register sets.
  logic [5*DIGITS-1:0] sh_codes_q, sh_codes_d;
  logic [DIGITS-1:0]   sh_mask_q, sh_mask_d;
  logic                sh_lz_q, sh_lz_d;
  logic [5*DIGITS-1:0] act_codes_q, act_codes_d;
  logic [DIGITS-1:0]   act_mask_q, act_mask_d;
  logic                act_lz_q, act_lz_d;

  // Blink state.
  logic [FrmW-1:0]   frm_cnt_q, frm_cnt_d;
  logic              blink_on_q, blink_on_d;

  logic              boundary;
  logic [DIGITS-1:0] idx_onehot;

  assign idx_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;

  // ---------------------------------------------------------------------------------------
  // Effective code of the digit about to enter SHOW
  // ---------------------------------------------------------------------------------------
  logic [4:0]        act_code [DIGITS];
  logic [DIGITS-1:0] lz_hit;
  logic              zeros_above;
  logic [4:0]        eff_code;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_unpack
    assign act_code[g] = act_codes_q[5*g +: 5];
  end

  // Walk from the leftmost digit down. A digit is a leading zero when it shows 0 and every
  // digit to its left is 0 or blank. Arrow codes break the run. Digit 0 is never blanked.
  always_comb begin
    lz_hit      = '0;
    zeros_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_hit[i]   = act_lz_q && (act_code[i] == CodeZero) && zeros_above;
      zeros_above = zeros_above &&
                    ((act_code[i] == CodeZero) || (act_code[i] == CodeBlank));
    end
  end

  always_comb begin
    eff_code = act_code[idx_q];
    if (lz_hit[idx_q]) begin
      eff_code = CodeBlank;
    end else if (act_mask_q[idx_q] && !blink_on_q) begin
      eff_code = CodeBlank;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Scan sequencing
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    dig_sel_d     = dig_sel_q;
    code_out_d    = code_out_q;
    frame_start_d = 1'b0;
    boundary      = 1'b0;

    unique case (state_q)
      StGuard: begin
        if (cnt_q == GuardLast) begin
          state_d    = StShow;
          cnt_d      = '0;
          dig_sel_d  = idx_onehot;
          code_out_d = eff_code;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          state_d    = StGuard;
          cnt_d      = '0;
          dig_sel_d  = '0;
          code_out_d = CodeBlank;
          if (idx_q == IdxLast) begin
            idx_d         = '0;
            boundary      = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StGuard;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Double buffering and blink phase
  // ---------------------------------------------------------------------------------------
  always_comb begin
    sh_codes_d  = sh_codes_q;
    sh_mask_d   = sh_mask_q;
    sh_lz_d     = sh_lz_q;
    act_codes_d = act_codes_q;
    act_mask_d  = act_mask_q;
    act_lz_d    = act_lz_q;
    pending_d   = pending_q;
    frm_cnt_d   = frm_cnt_q;
    blink_on_d  = blink_on_q;

    if (load_i) begin
      sh_codes_d = load_data_i;
      sh_mask_d  = blink_mask_i;
      sh_lz_d    = lz_blank_i;
      pending_d  = 1'b1;
    end

    if (boundary) begin
      // A load in the commit cycle bypasses the shadow set, so it is never left pending.
      if (load_i) begin
        act_codes_d = load_data_i;
        act_mask_d  = blink_mask_i;
        act_lz_d    = lz_blank_i;
      end else if (pending_q) begin
        act_codes_d = sh_codes_q;
        act_mask_d  = sh_mask_q;
        act_lz_d    = sh_lz_q;
      end
      pending_d = 1'b0;

      if (frm_cnt_q == FrmLast) begin
        frm_cnt_d  = '0;
        blink_on_d = !blink_on_q;
      end else begin
        frm_cnt_d = frm_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StGuard;
      idx_q         <= '0;
      cnt_q         <= '0;
      code_out_q    <= '0;
      dig_sel_q     <= '0;
      frame_start_q <= 1'b0;
      pending_q     <= 1'b0;
      sh_codes_q    <= '0;
      sh_mask_q     <= '0;
      sh_lz_q       <= 1'b0;
      act_codes_q   <= '0;
      act_mask_q    <= '0;
      act_lz_q      <= 1'b0;
      frm_cnt_q     <= '0;
      blink_on_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      code_out_q    <= code_out_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
      pending_q     <= pending_d;
      sh_codes_q    <= sh_codes_d;
      sh_mask_q     <= sh_mask_d;
      sh_lz_q       <= sh_lz_d;
      act_codes_q   <= act_codes_d;
      act_mask_q    <= act_mask_d;
      act_lz_q      <= act_lz_d;
      frm_cnt_q     <= frm_cnt_d;
      blink_on_q    <= blink_on_d;
    end
  end

  assign code_out_o    = code_out_q;
  assign dig_sel_o     = dig_sel_q;
  assign pending_o     = pending_q;
  assign frame_start_o = frame_start_q;

  // At most one digit is ever enabled, and nothing is sent to the decoder while all are off.
  a_dig_sel_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(dig_sel_q));
  a_guard_blank: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dig_sel_q == '0) |-> (code_out_q == CodeBlank));

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIGITS=4, SCAN_DIV=4, GUARD_CYC=1,
// BLINK_FRAMES=2). The driver pushes the expected code of every digit of a frame into a
// scoreboard queue at the frame start. The monitor pops one entry at each SHOW entry. The
// slot timing, frame_start and dig_sel are checked against a cycle count kept by the bench.
module tb_display_scan_ctrl;

  localparam int unsigned Digits      = 4;
  localparam int unsigned ScanDiv     = 4;
  localparam int unsigned GuardCyc    = 1;
  localparam int unsigned BlinkFrames = 2;
  localparam int          Slot        = GuardCyc + ScanDiv;
  localparam int          Frame       = Digits * Slot;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] load_data = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic [4:0]  code_out;
  logic [3:0]  dig_sel;
  logic        pending;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;  // rising edges since reset release

  logic [4:0] sb[$];
  logic [4:0] cur_exp = '0;

  // Bench-side picture of the register sets.
  logic [19:0] act_codes = '0, sh_codes = '0;
  logic [3:0]  act_mask = '0, sh_mask = '0;
  logic        act_lz = 1'b0, sh_lz = 1'b0;
  bit          tb_pending = 1'b0;

  display_scan_ctrl #(
    .DIGITS      (Digits),
    .SCAN_DIV    (ScanDiv),
    .GUARD_CYC   (GuardCyc),
    .BLINK_FRAMES(BlinkFrames)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (load),
    .load_data_i  (load_data),
    .blink_mask_i (blink_mask),
    .lz_blank_i   (lz_blank),
    .code_out_o   (code_out),
    .dig_sel_o    (dig_sel),
    .pending_o    (pending),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Expected code of digit i, written straight from the display rules.
  function automatic logic [4:0] model_eff(input logic [19:0] codes, input logic [3:0] mask,
                                           input logic lz, input logic on, input int i);
    logic [4:0] c;
    logic [4:0] cj;
    bit         all_above;
    c = codes[5*i +: 5];
    all_above = 1'b1;
    for (int j = i + 1; j < 4; j++) begin
      cj = codes[5*j +: 5];
      if (!((cj == 5'b10000) || (cj == 5'b00000))) all_above = 1'b0;
    end
    if (lz && (i != 0) && (c == 5'b10000) && all_above) return 5'b00000;
    if (mask[i] && !on) return 5'b00000;
    return c;
  endfunction

  // Monitor: slot timing, frame_start and codes, sampled on the falling edge.
  always @(negedge clk) begin
    int         pos;
    int         slot;
    logic [3:0] exp_sel;
    if (rst_n && (k > 0)) begin
      pos  = k % Slot;
      slot = (k % Frame) / Slot;
      exp_sel = 4'b0000;
      if (pos != 0) exp_sel = 4'b0001 << slot;
      check("dig_sel", {28'd0, dig_sel}, {28'd0, exp_sel});
      check("frame_start", {31'd0, frame_start}, {31'd0, ((k % Frame) == 0)});
      if (pos == 0) begin
        check("code_guard", {27'd0, code_out}, 32'd0);
      end else begin
        if (pos == 1) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            cur_exp = '0;
          end else begin
            cur_exp = sb.pop_front();
          end
        end
        check("code_show", {27'd0, code_out}, {27'd0, cur_exp});
      end
    end
  end

  // Wait for the falling edge at frame position p. Always advances at least one cycle.
  task automatic wait_pos(input int p);
    do @(negedge clk); while ((k % Frame) != p);
  endtask

  // Call at the falling edge of a frame's first cycle: commit the bench copy and queue
  // the four expected codes.
  task automatic begin_frame();
    int   n;
    logic on;
    n  = k / Frame;
    on = (((n / BlinkFrames) % 2) == 0);
    check("pending_at_frame", {31'd0, pending}, 32'd0);
    if (tb_pending) begin
      act_codes  = sh_codes;
      act_mask   = sh_mask;
      act_lz     = sh_lz;
      tb_pending = 1'b0;
    end
    for (int i = 0; i < 4; i++) sb.push_back(model_eff(act_codes, act_mask, act_lz, on, i));
  endtask

  task automatic load_now(input logic [19:0] d, input logic [3:0] m, input logic l);
    load       = 1'b1;
    load_data  = d;
    blink_mask = m;
    lz_blank   = l;
    sh_codes   = d;
    sh_mask    = m;
    sh_lz      = l;
    tb_pending = 1'b1;
    @(negedge clk);
    load       = 1'b0;
    load_data  = '0;
    blink_mask = '0;
    lz_blank   = 1'b0;
  endtask

  // From a frame start: load mid-frame, watch pending, then begin the next frame.
  task automatic load_mid(input logic [19:0] d, input logic [3:0] m, input logic l);
    wait_pos(3);
    load_now(d, m, l);
    check("pending_set", {31'd0, pending}, 32'd1);
    wait_pos(Frame - 1);
    check("pending_hold", {31'd0, pending}, 32'd1);
    @(negedge clk);
    begin_frame();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_code"}, {27'd0, code_out}, 32'd0);
    check({tag, "_sel"}, {28'd0, dig_sel}, 32'd0);
    check({tag, "_pend"}, {31'd0, pending}, 32'd0);
    check({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    begin_frame();                    // frame 0, blank
    wait_pos(0);
    begin_frame();                    // frame 1, blank

    // Load/commit: digit3..0 = 10011,10010,10001,00001
    load_mid({5'b10011, 5'b10010, 5'b10001, 5'b00001}, 4'b0000, 1'b0);          // frame 2
    // Leading-zero blanking A, B, C
    load_mid({5'b10000, 5'b10000, 5'b10101, 5'b10000}, 4'b0000, 1'b1);          // frame 3
    load_mid({5'b10000, 5'b10000, 5'b10000, 5'b10000}, 4'b0000, 1'b1);          // frame 4
    load_mid({5'b10000, 5'b10000, 5'b10101, 5'b10000}, 4'b0000, 1'b0);          // frame 5
    // Blink digit 2; the other digits carry visible codes
    load_mid({5'b10100, 5'b10111, 5'b10010, 5'b00011}, 4'b0100, 1'b0);          // frame 6
    repeat (4) begin
      wait_pos(0);
      begin_frame();                  // frames 7..10
    end

    // Race A: X then Y in one frame; only Y may ever show
    wait_pos(3);
    load_now({5'b11111, 5'b11110, 5'b11101, 5'b11100}, 4'b0000, 1'b0);
    wait_pos(8);
    load_now({5'b10001, 5'b00010, 5'b00011, 5'b11010}, 4'b0000, 1'b0);
    check("pending_race", {31'd0, pending}, 32'd1);
    wait_pos(Frame - 1);
    @(negedge clk);
    begin_frame();                    // frame 11 shows Y

    // Race B: load in the commit cycle is displayed next frame and never pends
    wait_pos(Frame - 1);
    load_now({5'b11001, 5'b11000, 5'b10111, 5'b10110}, 4'b0000, 1'b1);
    begin_frame();                    // frame 12 shows Z
    wait_pos(5);
    check("pending_bypass", {31'd0, pending}, 32'd0);

    // Reset during digit 2 SHOW with a load pending
    load_now({5'b10101, 5'b10101, 5'b10101, 5'b10101}, 4'b1111, 1'b0);
    check("pending_pre_rst", {31'd0, pending}, 32'd1);
    wait_pos(12);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    sb.delete();
    act_codes  = '0;
    act_mask   = '0;
    act_lz     = 1'b0;
    sh_codes   = '0;
    sh_mask    = '0;
    sh_lz      = 1'b0;
    tb_pending = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("midrst_hold");
    rst_n = 1'b1;
    begin_frame();                    // blank frame 0 after reset
    wait_pos(0);
    begin_frame();                    // blank frame 1
    wait_pos(0);
    check("sb_drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the multi-digit seven-segment display on the elevator board. It holds one 5-bit display code per digit, the same encoding the segment decoder consumes: 1xxxx = hex digit, 00000 = blank, 00001 = up arrow, 00010 = down arrow, 00011 = up and down. Each scan slot it presents one code to the shared decoder and drives the matching one-hot digit enable. It adds tear-free double-buffered loading, leading-zero blanking, per-digit blinking and an anti-ghosting guard gap.

## Interface
Parameters:
- DIGITS, 4, number of digits; legal range 2..8
- SCAN_DIV, 50000, clock cycles per digit SHOW phase; must be ≥1
- GUARD_CYC, 2, clock cycles per GUARD phase, during which all digits are off; must be ≥1
- BLINK_FRAMES, 64, full frames per blink half-period; must be ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe that captures load_data, blink_mask and lz_blank into the shadow registers
- load_data  in  5*DIGITS  digit codes; bits [5i+4:5i] belong to digit i, and digit 0 is rightmost
- blink_mask  in  DIGITS  1 = digit i blinks
- lz_blank  in  1  1 = leading-zero blanking enabled
- code_out  out  5  code sent to the segment decoder; registered
- dig_sel  out  DIGITS  one-hot active-high digit enable; registered
- pending  out  1  shadow registers hold data not yet committed
- frame_start  out  1  one-cycle pulse at each frame boundary

## Operation
- Register sets:
  - Shadow set: codes, mask, lz.
  - Active set: the same three fields. The display uses the active set only.
- Load:
  - A load captures into the shadow set and sets pending=1.
  - A repeat load while pending=1 overwrites the shadow set; the last load wins.
- Commit:
  - Commit happens only at a frame boundary, i.e. the transition from SHOW of digit DIGITS-1 into GUARD of digit 0.
  - At commit, active is loaded from shadow and pending is cleared.
  - If load is asserted in the commit cycle, the new load inputs are committed directly (bypass) and pending stays 0.
- FSM states: GUARD and SHOW, plus a digit index idx in 0..DIGITS-1.
  - GUARD: dig_sel=0 and code_out=00000 for GUARD_CYC cycles, then go to SHOW.
  - SHOW: dig_sel bit idx=1 and code_out=eff(idx) for SCAN_DIV cycles. Then idx increments (DIGITS-1 wraps to 0) and the FSM returns to GUARD.
- eff(i) is evaluated once, on SHOW entry, from the active set:
  - Leading-zero rule: if lz=1, i≠0, code(i)=10000, and every digit j>i has code 10000 or 00000, then eff(i)=00000.
  - Blink rule: otherwise, if mask[i]=1 and blink phase=OFF, then eff(i)=00000.
  - Otherwise eff(i)=code(i). Arrow codes are never treated as zeros.
  - Digit 0 is never LZ-blanked, but it can be blinked.
- Blink phase:
  - Resets to ON.
  - A frame counter increments at each frame boundary. When it reaches BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - The toggle takes effect at the same boundary as a commit.
- Counters must be sized by $clog2 of the largest value they hold. Counters must not overflow at the maximum parameter values.

## Timing
- Reset (asynchronous) sets:
  - code_out=00000, dig_sel=0, pending=0, frame_start=0.
  - Active and shadow sets all 0.
  - State GUARD, idx=0, all counters 0, blink ON.
- A reset asserted mid-SHOW or mid-GUARD clears everything immediately and aborts any pending load.
- After rst_n rises, the first GUARD lasts GUARD_CYC cycles. dig_sel=…0001 then appears on the next cycle.
- Slot length = GUARD_CYC+SCAN_DIV cycles. Frame length = DIGITS × slot.
- frame_start is high for exactly the first cycle of digit-0 GUARD after a wrap. It is not pulsed for the initial post-reset GUARD.
- Load-to-display latency:
  - pending falls in the commit cycle.
  - New codes appear on code_out when digit 0 enters SHOW, GUARD_CYC cycles after the boundary.
- dig_sel and code_out change on the same edge, and never overlap two digits.

## Test plan
Bench parameters for all scenarios: DIGITS=4, SCAN_DIV=4, GUARD_CYC=1, BLINK_FRAMES=2 (slot=5 cycles, frame=20 cycles).
- Reset/idle:
  - Stimulus: hold rst_n=0, then release it.
  - Required: all outputs are 0 during reset. Then dig_sel steps 0000(1)→0001(4)→0000(1)→0010(4)→…, with code_out=00000 throughout and frame_start high only at the wrap to digit 0.
- Load/commit:
  - Stimulus: mid-frame, load digit3..0 = 10011,10010,10001,00001.
  - Required: pending=1 until the boundary, then 0. The next frame shows digit0=00001, digit1=10001, digit2=10010, digit3=10011 with the correct dig_sel. The old codes are held until the boundary.
- Leading-zero blanking:
  - Stimulus A: lz=1, load 10000,10000,10101,10000 (digit3..0).
    Required A: digit3=00000, digit2=00000, digit1=10101, digit0=10000.
  - Stimulus B: lz=1, all digits 10000.
    Required B: only digit0 shows 10000.
  - Stimulus C: lz=0, same data as A.
    Required C: all four codes are shown unchanged.
- Blink:
  - Stimulus: load digit2=10111 with mask=0100.
  - Required: digit2 shows 10111 for 2 frames, then 00000 for 2 frames, repeating. The other digits are unaffected.
- Load races:
  - Stimulus A: two loads (X, then Y) inside one frame.
    Required A: Y is committed and X never appears.
  - Stimulus B: a load asserted in the commit cycle.
    Required B: that data is displayed in the next frame, and pending stays 0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during digit2 SHOW with pending=1.
  - Required: outputs are 0 immediately. After release, the display is blank and pending=0.
